ram_loader: RTL and testbench
=============================

# ram_loader

Upstream fill stage for the 512×8 playback RAM. Accepts a byte stream over a valid/ready handshake, writes it into block RAM from address 0, and then plays the loaded bytes back cyclically as a registered byte stream for the pin-driver stage. It replaces the fixed `$readmemh` image, so RAM contents can be loaded at run time from UART or SPI front-ends.

## Interface
- `ADDR_W`, 9: RAM address width; depth is `2**ADDR_W` (512).
- `DATA_W`, 8: byte width.
- `CLK` in 1: 16 MHz system clock; all logic is on the rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream byte valid.
- `in_ready` out 1: loader accepts a byte this cycle.
- `in_data` in `DATA_W`: byte to write.
- `in_last` in 1: marks the final byte of the image; qualified by `in_valid`.
- `reload` in 1: single-cycle request to discard the image and start a new load.
- `playing` out 1: high in the PLAY state.
- `length` out `ADDR_W+1`: number of bytes in the loaded image, 1..512.
- `out_data` out `DATA_W`: registered playback byte.
- `out_addr` out `ADDR_W`: address that `out_data` was read from.
- `out_valid` out 1: `out_data` holds a real RAM byte.

## Operation
- States: LOAD and PLAY. Reset enters LOAD.
- **LOAD**
  - `in_ready = ~reload`.
  - A handshake (`in_valid & in_ready`) writes `in_data` to `mem[wr_addr]` and increments `wr_addr`.
  - If the accepted byte has `in_last=1`, or `wr_addr == 2**ADDR_W-1`, then next state is PLAY and `length` is set to `wr_addr+1`.
  - Bytes beyond 512 cannot be accepted, because the state changes before a 513th write.
- **PLAY**
  - `in_ready=0`.
  - `rd_addr` starts at 0 and increments every cycle.
  - When `rd_addr == length-1`, the next `rd_addr` is 0 (wraps at `length`, not at depth).
- **reload**
  - In PLAY: next state is LOAD, and `wr_addr`, `rd_addr` and `out_valid` are cleared.
  - In LOAD: `wr_addr` is cleared and `in_ready` is forced low that cycle. A simultaneous `in_valid` byte is not accepted.
  - `reload` has priority over `in_last` in the same cycle.
  - `length` holds its last value until the next load completes.
- Reset values: state LOAD, `wr_addr`=0, `rd_addr`=0, `length`=0, `out_data`=0, `out_addr`=0, `out_valid`=0, `playing`=0.
  - `in_ready`=0 while `RST_N` is low and 1 from the first cycle after deassertion.
  - RAM contents are not reset.
- Reset asserted mid-load or mid-play returns to LOAD immediately. The partial image is abandoned.

## Timing
- Write latency is 1 cycle: data accepted at edge N is readable from edge N+1.
- Cycle P is the first PLAY cycle; RAM reads at address 0 then.
  - At edge P+1: `out_data = mem[0]`, `out_addr = 0`, `out_valid = 1`.
  - Thereafter one byte per cycle, with no bubbles.
- Read latency is 1 cycle, matching the downstream pin stage's registered read.
- `playing` rises on the edge that enters PLAY. `out_valid` rises one cycle later.
- After `reload`, `out_valid` is 0 on the next edge. `out_data` holds its last value.
- Image length 1: `out_data` repeats `mem[0]` every cycle.

## Structure
- Package `ram_loader_pkg` holds:
  - the state enum (`ST_LOAD`, `ST_PLAY`);
  - the default `ADDR_W`/`DATA_W`;
  - `DEPTH = 2**ADDR_W`.
- Sub-module `ram_dp_512x8`: one write port, one registered read port, no reset on the array. It must infer a single SB_RAM40_4K.
- The FSM, pointers and handshake live in `ram_loader`.

## Test plan
- Reset, then stream bytes 0x10,0x11,0x12 with `in_last` on 0x12 → `length`=3; `out_data` cycles 0x10,0x11,0x12,0x10… with `out_addr` 0,1,2,0; first `out_valid` one cycle after `playing` rises.
- Stream 512 bytes `i[7:0]` without `in_last` → PLAY after byte 511; `in_ready`=0 on the next cycle; `length`=512; playback wraps 0x...FF→0x00 at address 511→0.
- `in_valid` toggled with gaps (valid 1,0,0,1,1) → only handshaked bytes are written; `wr_addr` counts exactly 3.
- During PLAY assert `reload`, load a single byte 0xA5 with `in_last` → `out_valid` drops for the load; `length`=1; `out_data`=0xA5 constant.
- `reload` and `in_valid`+`in_last` in the same LOAD cycle → byte not accepted, `wr_addr`=0, state stays LOAD.
- Assert `RST_N`=0 mid-playback (asynchronously, between edges) → outputs go to reset values immediately; a new 2-byte load then plays correctly.

Source files
------------

// File: rtl/ram_loader_pkg.sv
// Shared types and default geometry for the run-time loadable playback RAM.
package ram_loader_pkg;

  localparam int unsigned DEF_ADDR_W = 9;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEPTH      = 2 ** DEF_ADDR_W;

  typedef enum logic {
    ST_LOAD,
    ST_PLAY
  } state_e;

endpackage

// File: rtl/ram_dp_512x8.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// No reset on the array or the read register so it maps onto a single SB_RAM40_4K.
module ram_dp_512x8
  import ram_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              CLK,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port and registered read port; read data holds while rd_en is low.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/ram_loader.sv
// Loads a byte image over valid/ready into block RAM, then replays it cyclically.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              reload,
  output logic              playing,
  output logic [ADDR_W:0]   length,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid
);

  localparam logic [ADDR_W-1:0] AddrOne = 1;
  localparam logic [ADDR_W:0]   LenOne  = 1;

  state_e            state_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [ADDR_W:0]   length_q;
  logic              playing_q;
  logic              out_valid_q;
  logic              data_seen_q;
  logic              wr_en;
  logic              rd_en;
  logic              rd_wrap;
  logic [DATA_W-1:0] rd_data;

  // Handshake and RAM port controls.
  always_comb begin
    in_ready = RST_N & (state_q == ST_LOAD) & ~reload;
    wr_en    = in_valid & in_ready;
    rd_en    = (state_q == ST_PLAY) & ~reload;
    rd_wrap  = ({1'b0, rd_addr_q} == (length_q - LenOne));
  end

  ram_dp_512x8 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .CLK     (CLK),
    .wr_en   (wr_en),
    .wr_addr (wr_addr_q),
    .wr_data (in_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr_q),
    .rd_data (rd_data)
  );

  // Load/play FSM with write and read pointers and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_LOAD;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      out_addr_q  <= '0;
      length_q    <= '0;
      playing_q   <= 1'b0;
      out_valid_q <= 1'b0;
      data_seen_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_LOAD: begin
          out_valid_q <= 1'b0;
          if (reload) begin
            wr_addr_q <= '0;
          end else if (wr_en) begin
            wr_addr_q <= wr_addr_q + AddrOne;
            // Last RAM slot also ends the load, so a 513th byte is never accepted.
            if (in_last || (wr_addr_q == '1)) begin
              state_q   <= ST_PLAY;
              playing_q <= 1'b1;
              length_q  <= {1'b0, wr_addr_q} + LenOne;
            end
          end
        end
        ST_PLAY: begin
          if (reload) begin
            state_q     <= ST_LOAD;
            playing_q   <= 1'b0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            out_valid_q <= 1'b0;
          end else begin
            rd_addr_q   <= rd_wrap ? '0 : rd_addr_q + AddrOne;
            out_addr_q  <= rd_addr_q;
            out_valid_q <= 1'b1;
            data_seen_q <= 1'b1;
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  // The RAM read register has no reset; mask it to zero until a real read has landed.
  always_comb begin
    out_data = data_seen_q ? rd_data : '0;
  end

  assign playing   = playing_q;
  assign length    = length_q;
  assign out_addr  = out_addr_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: behavioural image/playback model plus directed
// and randomized loads.
module tb_ram_loader;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       reload = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       playing;
  logic       out_valid;
  logic [9:0] length;
  logic [7:0] out_data;
  logic [8:0] out_addr;

  int total = 0;
  int bad   = 0;

  ram_loader dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .reload    (reload),
    .playing   (playing),
    .length    (length),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_valid (out_valid)
  );

  initial forever #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_play  = 0;
  int         m_count = 0;
  int         m_len   = 0;
  int         m_idx   = 0;
  bit         m_ov    = 0;
  logic [7:0] m_od    = 8'h00;
  int         m_oa    = 0;
  logic [7:0] m_mem [512];

  always @(negedge RST_N) begin
    m_play = 0; m_count = 0; m_len = 0; m_idx = 0;
    m_ov = 0; m_od = 8'h00; m_oa = 0;
  end

  always @(posedge CLK) begin
    if (RST_N) begin
      if (!m_play) begin
        m_ov = 0;
        if (reload) begin
          m_count = 0;
        end else if (in_valid) begin
          m_mem[m_count] = in_data;
          m_count++;
          if (in_last || m_count == 512) begin
            m_play = 1; m_len = m_count; m_idx = 0; m_count = 0;
          end
        end
      end else if (reload) begin
        m_play = 0; m_count = 0; m_ov = 0; m_idx = 0;
      end else begin
        m_od  = m_mem[m_idx];
        m_oa  = m_idx;
        m_ov  = 1;
        m_idx = (m_idx + 1) % m_len;
      end
    end
  end

  // Compare all outputs against the model every cycle, away from the active edge.
  always @(negedge CLK) begin
    check("m_playing",   playing,   m_play);
    check("m_length",    length,    m_len);
    check("m_out_valid", out_valid, m_ov);
    check("m_out_data",  out_data,  m_od);
    check("m_out_addr",  out_addr,  m_oa);
    check("m_in_ready",  in_ready,  RST_N && !m_play && !reload);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    step();
    reload = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input bit last, input int gap);
    in_valid = 1'b0;
    repeat (gap) step();
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_play(input int bound);
    int n = 0;
    while (!playing && n < bound) begin
      step();
      n++;
    end
    check("wait_play", playing, 1);
  endtask

  logic [7:0] exp3 [4];

  initial begin
    exp3[0] = 8'h10; exp3[1] = 8'h11; exp3[2] = 8'h12; exp3[3] = 8'h10;

    // Reset values
    repeat (3) @(posedge CLK);
    #1;
    check("rst_playing", playing, 0);
    check("rst_length", length, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 0);
    RST_N = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Three-byte image
    send(8'h10, 0, 0);
    send(8'h11, 0, 0);
    send(8'h12, 1, 0);
    check("t1_playing", playing, 1);
    check("t1_valid_lags", out_valid, 0);
    check("t1_length", length, 3);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t1_data", out_data, exp3[i]);
      check("t1_addr", out_addr, i % 3);
      check("t1_valid", out_valid, 1);
    end

    // Full 512-byte image without in_last
    pulse_reload();
    check("t2_reload_valid", out_valid, 0);
    check("t2_reload_playing", playing, 0);
    for (int i = 0; i < 512; i++) begin
      send(i[7:0], 0, 0);
    end
    check("t2_playing", playing, 1);
    check("t2_in_ready", in_ready, 0);
    check("t2_length", length, 512);
    begin
      int n = 0;
      while (!(out_valid && out_addr == 9'd511) && n < 600) begin
        step();
        n++;
      end
      check("t2_reach_511", out_addr, 511);
      check("t2_data_ff", out_data, 8'hFF);
      step();
      check("t2_wrap_addr", out_addr, 0);
      check("t2_wrap_data", out_data, 8'h00);
    end

    // Reload during play, single-byte image
    pulse_reload();
    check("t4_valid_drop", out_valid, 0);
    send(8'hA5, 1, 0);
    check("t4_length", length, 1);
    repeat (4) begin
      step();
      check("t4_data", out_data, 8'hA5);
      check("t4_addr", out_addr, 0);
    end

    // Gapped valid: 1,0,0,1,1
    pulse_reload();
    send(8'h20, 0, 0);
    send(8'h21, 0, 2);
    send(8'h22, 1, 0);
    check("t3_length", length, 3);
    step();
    check("t3_first", out_data, 8'h20);

    // reload together with in_valid+in_last in LOAD
    pulse_reload();
    reload = 1'b1; in_valid = 1'b1; in_last = 1'b1; in_data = 8'h77;
    #1;
    check("t5_in_ready_low", in_ready, 0);
    step();
    reload = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    check("t5_still_load", playing, 0);
    send(8'h31, 0, 0);
    send(8'h32, 1, 0);
    check("t5_length", length, 2);
    step();
    check("t5_first", out_data, 8'h31);
    check("t5_first_addr", out_addr, 0);

    // Asynchronous reset mid-playback
    repeat (3) step();
    #2;
    RST_N = 1'b0;
    #1;
    check("t6_playing", playing, 0);
    check("t6_out_valid", out_valid, 0);
    check("t6_out_data", out_data, 0);
    check("t6_out_addr", out_addr, 0);
    check("t6_length", length, 0);
    check("t6_in_ready", in_ready, 0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    send(8'h55, 0, 0);
    send(8'h66, 1, 0);
    check("t6_new_length", length, 2);
    step();
    check("t6_d0", out_data, 8'h55);
    step();
    check("t6_d1", out_data, 8'h66);
    check("t6_a1", out_addr, 1);
    step();
    check("t6_d2", out_data, 8'h55);

    // Randomized loads with gaps and occasional mid-load reloads
    for (int r = 0; r < 30; r++) begin
      int len;
      if (playing) pulse_reload();
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 19) == 0) pulse_reload();
        send(8'($urandom), i == len - 1, $urandom_range(0, 2));
      end
      wait_play(5);
      repeat ($urandom_range(1, 60)) step();
      // Reload while upstream is offering a byte
      in_valid = 1'($urandom);
      in_data  = 8'($urandom);
      pulse_reload();
      in_valid = 1'b0;
    end

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
